credit_to_valrdy: RTL and testbench

Bridge from a credit-based flit channel to a valid/ready channel. Flits arriving on the credit side (`valid_in`/`data_in`) are stored in an internal FIFO and presented on the val/rdy side (`valid_out`/`data_out`/`ready_out`). Each flit accepted downstream returns one credit upstream as a single-cycle `yummy_in` pulse. The block sits at a NoC/chip boundary, where an upstream credit-flow sender feeds a downstream val/rdy consumer.

---
 rtl/credit_to_valrdy.sv | 68 ++++++
 tb/tb_credit_to_valrdy.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/credit_to_valrdy.sv
// Credit-flow to valid/ready bridge: buffers incoming flits in a small FIFO and
// returns one registered credit pulse (yummy_in) for each flit taken downstream.
module credit_to_valrdy #(
   parameter int DATA_WIDTH   = 64,
   parameter int BUFFER_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  valid_in,
   output logic                  yummy_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid_out,
   input  logic                  ready_out
);

   localparam int PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUFFER_DEPTH);

   logic [DATA_WIDTH-1:0] mem [BUFFER_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next;
   logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next;
   logic [CNT_W-1:0]      count_reg, count_next;
   logic                  yummy_reg;
   logic                  enq, deq;

   // A write into a full FIFO is dropped even if the head leaves this cycle;
   // the freed slot only exists from the next edge on.
   assign enq = valid_in && (count_reg != FULL_CNT);
   assign deq = (count_reg != '0) && ready_out;

   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      count_next  = count_reg;
      if (enq) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      if (deq) rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      if (enq && !deq)
         count_next = count_reg + CNT_W'(1);
      else if (!enq && deq)
         count_next = count_reg - CNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         yummy_reg  <= 1'b0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
         yummy_reg  <= deq;
      end
   end

   // Storage is not reset; empty-state output is masked below instead.
   always_ff @(posedge clk) begin
      if (enq) mem[wr_ptr_reg] <= data_in;
   end

   assign valid_out = (count_reg != '0);
   assign data_out  = valid_out ? mem[rd_ptr_reg] : '0;
   assign yummy_in  = yummy_reg;

endmodule

// File: tb/tb_credit_to_valrdy.sv
// Directed bench for credit_to_valrdy: reset, burst, backpressure, overflow,
// streaming and mid-stream asynchronous reset.
module tb_credit_to_valrdy;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] data_in;
   logic        valid_in;
   logic        yummy_in;
   logic [63:0] data_out;
   logic        valid_out;
   logic        ready_out;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   credit_to_valrdy #(.DATA_WIDTH(64), .BUFFER_DEPTH(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .data_in   (data_in),
      .valid_in  (valid_in),
      .yummy_in  (yummy_in),
      .data_out  (data_out),
      .valid_out (valid_out),
      .ready_out (ready_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk3(input string tag, input logic v, input logic [63:0] d, input logic y);
      chk({tag, ".valid"}, {63'd0, valid_out}, {63'd0, v});
      chk({tag, ".data"},  data_out, d);
      chk({tag, ".yummy"}, {63'd0, yummy_in}, {63'd0, y});
      $display("step %-12s valid=%0b data=%h yummy=%0b", tag, valid_out, data_out, yummy_in);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset     = 1'b0;
      valid_in  = 1'b0;
      ready_out = 1'b1;
      data_in   = 64'h0;

      // Reset held for 500 cycles
      #1;
      for (int i = 0; i < 500; i++) begin
         tick();
         chk3("reset", 1'b0, 64'h0, 1'b0);
      end

      // Three-flit burst
      reset    = 1'b1;
      valid_in = 1'b1;
      data_in  = 64'h800000008084c008;
      tick();
      chk3("burst0", 1'b1, 64'h800000008084c008, 1'b0);
      data_in = 64'h00fff10100000300;
      tick();
      chk3("burst1", 1'b1, 64'h00fff10100000300, 1'b1);
      data_in = 64'h0;
      tick();
      chk3("burst2", 1'b1, 64'h0, 1'b1);
      valid_in = 1'b0;
      tick();
      chk3("burst_end", 1'b0, 64'h0, 1'b1);
      tick();
      chk3("burst_idle", 1'b0, 64'h0, 1'b0);
      tick();
      chk3("empty_rdy", 1'b0, 64'h0, 1'b0);

      // Backpressure: fill four entries
      ready_out = 1'b0;
      valid_in  = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         data_in = 64'(i);
         tick();
         chk3("bp_fill", 1'b1, 64'h1, 1'b0);
      end

      // Overflow while stalled, then overflow on the same edge as a dequeue
      data_in = 64'h5;
      tick();
      chk3("ovf_stall", 1'b1, 64'h1, 1'b0);
      ready_out = 1'b1;
      data_in   = 64'h6;
      tick();
      chk3("ovf_deq", 1'b1, 64'h2, 1'b1);
      valid_in = 1'b0;
      tick();
      chk3("drain3", 1'b1, 64'h3, 1'b1);
      tick();
      chk3("drain4", 1'b1, 64'h4, 1'b1);
      tick();
      chk3("drain_end", 1'b0, 64'h0, 1'b1);
      tick();
      chk3("drain_idle", 1'b0, 64'h0, 1'b0);

      // Simultaneous enqueue/dequeue with two flits resident
      ready_out = 1'b0;
      valid_in  = 1'b1;
      data_in   = 64'hA0;
      tick();
      data_in = 64'hA1;
      tick();
      chk3("pre_stream", 1'b1, 64'hA0, 1'b0);
      ready_out = 1'b1;
      for (int k = 0; k < 6; k++) begin
         data_in = 64'hA2 + 64'(k);
         tick();
         chk3("stream", 1'b1, 64'hA1 + 64'(k), 1'b1);
      end
      valid_in = 1'b0;
      tick();
      chk3("stream_t1", 1'b1, 64'hA7, 1'b1);
      tick();
      chk3("stream_t2", 1'b0, 64'h0, 1'b1);
      tick();
      chk3("stream_idle", 1'b0, 64'h0, 1'b0);

      // Mid-stream reset with three flits buffered and a credit in flight
      ready_out = 1'b0;
      valid_in  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         data_in = 64'hB1 + 64'(i);
         tick();
      end
      valid_in  = 1'b0;
      ready_out = 1'b1;
      tick();
      chk3("pre_rst", 1'b1, 64'hB2, 1'b1);
      #2;
      reset = 1'b0;
      #1;
      chk3("async_rst", 1'b0, 64'h0, 1'b0);
      tick();
      tick();
      reset = 1'b1;
      tick();
      chk3("post_rst", 1'b0, 64'h0, 1'b0);
      valid_in = 1'b1;
      data_in  = 64'hC0;
      tick();
      chk3("post_rst_wr", 1'b1, 64'hC0, 1'b0);
      valid_in = 1'b0;
      tick();
      chk3("post_rst_rd", 1'b0, 64'h0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
